// File: rtl/user_project_mux.sv
// -----------------------------------------------------------------------------
// user_project_mux
//
// Hosts NUM_SLOTS independent user projects behind one Caravel user-area
// interface.
//   * Management Wishbone accesses are decoded on wbs_adr_i[23:20]:
//     slot index (< NUM_SLOTS), control bank (4'hF) or unmapped.
//   * The control bank holds CTRL (active_slot, irq_en, soft_rst) at offset
//     0x0 and STATUS (timeout flag, last timed-out slot) at offset 0x4.
//   * The GPIO pads are driven by the slot named in active_slot.
//   * Slot interrupts are masked by irq_en and OR-merged onto user_irq.
//
// Optional build macro: USER_PROJECT_MUX_TIMEOUT_EN
//   defined   : a slot that does not ack within TIMEOUT_CYCLES is aborted,
//               ERR_DATA is returned and STATUS records the event.
//   undefined : forwarded accesses wait indefinitely; STATUS reads 0.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wbs_*                         management Wishbone slave port
//   slot_cyc_o/slot_stb_o         one-hot per-slot cycle/strobe
//   slot_we_o/sel/adr/dat_o       shared, registered request fields
//   slot_ack_i, slot_dat_i        per-slot ack and read data (32 bits each)
//   slot_rst_o                    per-slot registered reset
//   io_in, slot_io_in_o           pad inputs, broadcast to all slots
//   slot_io_out_i/slot_io_oeb_i   per-slot pad drive (IO_PADS bits each)
//   io_out, io_oeb                pad drive of the active slot
//   slot_irq_i, user_irq          per-slot irqs (3 each), merged irqs
// -----------------------------------------------------------------------------
module user_project_mux #(
  parameter int          NUM_SLOTS      = 4,
  parameter int          IO_PADS        = 38,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  output logic [NUM_SLOTS-1:0]         slot_cyc_o,
  output logic [NUM_SLOTS-1:0]         slot_stb_o,
  output logic                         slot_we_o,
  output logic [3:0]                   slot_sel_o,
  output logic [31:0]                  slot_adr_o,
  output logic [31:0]                  slot_dat_o,
  input  logic [NUM_SLOTS-1:0]         slot_ack_i,
  input  logic [NUM_SLOTS*32-1:0]      slot_dat_i,
  output logic [NUM_SLOTS-1:0]         slot_rst_o,
  input  logic [IO_PADS-1:0]           io_in,
  output logic [IO_PADS-1:0]           slot_io_in_o,
  input  logic [NUM_SLOTS*IO_PADS-1:0] slot_io_out_i,
  input  logic [NUM_SLOTS*IO_PADS-1:0] slot_io_oeb_i,
  output logic [IO_PADS-1:0]           io_out,
  output logic [IO_PADS-1:0]           io_oeb,
  input  logic [NUM_SLOTS*3-1:0]       slot_irq_i,
  output logic [2:0]                   user_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]  CTRL_IDX    = 4'hF;
  localparam logic [3:0]  SLOT_LIMIT  = 4'(NUM_SLOTS);
  localparam logic [19:0] OFS_CTRL    = 20'h0_0000;
  localparam logic [19:0] OFS_STATUS  = 20'h0_0004;

  state_t state, state_next;

  // Latched request
  logic [2:0]           idx_q;
  logic [31:0]          rdata_q;

  // Control bank
  logic [2:0]           active_slot;
  logic [NUM_SLOTS-1:0] irq_en;
  logic [NUM_SLOTS-1:0] soft_rst;

  // Request decode (valid only while the FSM is IDLE)
  logic        req;
  logic [3:0]  req_idx;
  logic        req_slot;
  logic        req_ctrl;
  logic        accept;
  logic        ctrl_wr;
  logic        status_wr;
  logic [31:0] ctrl_rdata;
  logic [31:0] status_rdata;

  // Selected-slot response
  logic        sel_ack;
  logic [31:0] sel_rdata;
  logic        tmo_hit;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign req_idx   = wbs_adr_i[23:20];
  assign req_slot  = (req_idx < SLOT_LIMIT);
  assign req_ctrl  = (req_idx == CTRL_IDX);
  assign accept    = (state == IDLE) & req;
  assign ctrl_wr   = accept & req_ctrl & wbs_we_i & (wbs_adr_i[19:0] == OFS_CTRL);
  assign status_wr = accept & req_ctrl & wbs_we_i & (wbs_adr_i[19:0] == OFS_STATUS);

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (idx_q == 3'(k)) begin
        sel_ack   = slot_ack_i[k];
        sel_rdata = slot_dat_i[32*k +: 32];
      end
    end
  end

`ifdef USER_PROJECT_MUX_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_flag;
  logic [2:0]  tmo_slot;

  // Counter holds the number of cycles already spent in FWD; the abort fires
  // in the TIMEOUT_CYCLES-th cycle unless the slot acks in that same cycle.
  assign tmo_hit = (state == FWD) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
      tmo_slot <= '0;
    end else begin
      tmo_cnt <= (state == FWD) ? tmo_cnt + 16'd1 : 16'd0;
      if (tmo_hit && wbs_cyc_i && !sel_ack) begin
        tmo_flag <= 1'b1;
        tmo_slot <= idx_q;
      end else if (status_wr && wbs_sel_i[0] && wbs_dat_i[0]) begin
        tmo_flag <= 1'b0;
      end
    end
  end

  assign status_rdata = {21'd0, tmo_slot, 7'd0, tmo_flag};
`else
  logic unused_timeout_cfg;
  assign tmo_hit            = 1'b0;
  assign status_rdata       = '0;
  assign unused_timeout_cfg = ^{ERR_DATA, 32'(TIMEOUT_CYCLES), status_wr};
`endif

  always_comb begin
    ctrl_rdata = '0;
    if (wbs_adr_i[19:0] == OFS_CTRL) begin
      ctrl_rdata[2:0]             = active_slot;
      ctrl_rdata[8 +: NUM_SLOTS]  = irq_en;
      ctrl_rdata[16 +: NUM_SLOTS] = soft_rst;
    end else if (wbs_adr_i[19:0] == OFS_STATUS) begin
      ctrl_rdata = status_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = req_slot ? FWD : RESP;
      // Master withdrawing cyc abandons the access without an ack.
      FWD: begin
        if (!wbs_cyc_i)              state_next = IDLE;
        else if (sel_ack || tmo_hit) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    slot_cyc_o = '0;
    slot_stb_o = '0;
    wbs_ack_o  = 1'b0;
    case (state)
      FWD: begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (idx_q == 3'(k)) begin
            slot_cyc_o[k] = 1'b1;
            slot_stb_o[k] = 1'b1;
          end
        end
      end
      RESP:    wbs_ack_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and response data
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx_q      <= '0;
      slot_we_o  <= 1'b0;
      slot_sel_o <= '0;
      slot_adr_o <= '0;
      slot_dat_o <= '0;
      rdata_q    <= '0;
    end else if (accept) begin
      idx_q      <= req_idx[2:0];
      slot_we_o  <= wbs_we_i;
      slot_sel_o <= wbs_sel_i;
      slot_adr_o <= wbs_adr_i;
      slot_dat_o <= wbs_dat_i;
      // Control reads return the bank contents, unmapped reads return 0.
      rdata_q    <= req_ctrl ? ctrl_rdata : 32'd0;
    end else if (state == FWD && wbs_cyc_i) begin
      // A real ack beats a simultaneous timeout.
      if (sel_ack)      rdata_q <= sel_rdata;
      else if (tmo_hit) rdata_q <= ERR_DATA;
    end
  end

  assign wbs_dat_o = rdata_q;

  // ---------------------------------------------------------------------------
  // CTRL register and per-slot resets
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      active_slot <= '0;
      irq_en      <= '0;
      soft_rst    <= '0;
      slot_rst_o  <= '1;
    end else begin
      slot_rst_o <= soft_rst;
      if (ctrl_wr) begin
        // An out-of-range slot number would select no pad driver; drop it.
        if (wbs_sel_i[0] && ({1'b0, wbs_dat_i[2:0]} < SLOT_LIMIT))
          active_slot <= wbs_dat_i[2:0];
        if (wbs_sel_i[1]) irq_en   <= wbs_dat_i[8 +: NUM_SLOTS];
        if (wbs_sel_i[2]) soft_rst <= wbs_dat_i[16 +: NUM_SLOTS];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pad mux and interrupt merge
  // ---------------------------------------------------------------------------
  assign slot_io_in_o = io_in;

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (active_slot == 3'(k)) begin
        io_out = slot_io_out_i[IO_PADS*k +: IO_PADS];
        io_oeb = slot_io_oeb_i[IO_PADS*k +: IO_PADS];
      end
    end
  end

  always_comb begin
    user_irq = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      user_irq = user_irq | (slot_irq_i[3*k +: 3] & {3{irq_en[k]}});
    end
  end

endmodule

// File: doc/user_project_mux.md
Name: user_project_mux

Overview:
- Multi-slot successor to the single-project wrapper: hosts NUM_SLOTS independent user projects behind one Caravel user-area interface.
- Decodes management Wishbone accesses to per-slot buses and holds a small control/status register bank.
- Routes the GPIO pads to one runtime-selected slot.
- Masks and merges slot interrupts onto user_irq.

Parameters:
- NUM_SLOTS, 4: number of hosted projects (1..8).
- IO_PADS, 38: GPIO pad count, equal to `MPRJ_IO_PADS.
- TIMEOUT_CYCLES, 255: cycles to wait for a slot ack before aborting (1..65535).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  mgmt Wishbone control.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  ack to mgmt.
- wbs_dat_o  out  32  read data to mgmt.
- slot_cyc_o, slot_stb_o  out  NUM_SLOTS  per-slot cyc/stb (one-hot).
- slot_we_o  out  1  shared.
- slot_sel_o  out  4  shared.
- slot_adr_o  out  32  shared, registered copy of wbs_adr_i.
- slot_dat_o  out  32  shared write data.
- slot_ack_i  in  NUM_SLOTS  per-slot ack.
- slot_dat_i  in  NUM_SLOTS*32  per-slot read data; slot k at [32k+31:32k].
- slot_rst_o  out  NUM_SLOTS  per-slot reset.
- io_in  in  IO_PADS  pad inputs.
- slot_io_in_o  out  IO_PADS  io_in broadcast to all slots, unregistered.
- slot_io_out_i, slot_io_oeb_i  in  NUM_SLOTS*IO_PADS  per-slot pad drive.
- io_out, io_oeb  out  IO_PADS  pad drive from active slot.
- slot_irq_i  in  NUM_SLOTS*3  per-slot irq lines.
- user_irq  out  3  merged irq.

Behaviour:
- Decode uses wbs_adr_i[23:20] = idx.
  - idx < NUM_SLOTS: slot access.
  - idx = 4'hF: control bank.
  - Any other idx: unmapped.
- CTRL register at offset 0x0, R/W:
  - [2:0] active_slot.
  - [15:8] irq_en, one bit per slot.
  - [23:16] soft_rst, one bit per slot.
  - Writes honour wbs_sel_i per byte.
  - Writing an active_slot value >= NUM_SLOTS is ignored; the field keeps its old value.
- STATUS register at offset 0x4:
  - [0] timeout flag; write 1 to clear.
  - [10:8] slot that last timed out, read-only.
  - Other offsets in the control bank read 0; writes to them are ignored.
- FSM states: IDLE, FWD, RESP.
  - IDLE: on cyc&stb, latch adr/dat/sel/we. Slot access goes to FWD. Control or unmapped access goes to RESP.
  - FWD: slot_cyc_o[idx] and slot_stb_o[idx] high; timeout counter runs.
    - On slot_ack_i[idx]: latch slot_dat_i, go to RESP.
    - When the counter reaches TIMEOUT_CYCLES: data = ERR_DATA, set timeout flag, record slot, go to RESP.
  - RESP: wbs_ack_o high for exactly one cycle with registered wbs_dat_o, then IDLE.
- Latencies:
  - Control or unmapped access: ack on 2nd cycle after stb is sampled.
  - Slot access: ack 1 cycle after slot ack.
- Unmapped reads return 0; unmapped writes are discarded and still acked.
- Acks arriving from non-selected slots are ignored.
- A slot ack arriving in the same cycle as the timeout wins: real data is returned and no flag is set.
- Timeout on a write still acks mgmt; the write is lost and the flag is set.
- cyc dropping during FWD: abort to IDLE next cycle, no ack to mgmt.
- slot_rst_o[k] = wb_rst_i | soft_rst[k], registered.
  - A slot held in reset can still be addressed; the access times out.
- IO mux is combinational from the active_slot register:
  - io_out = slot_io_out_i[active_slot].
  - io_oeb = slot_io_oeb_i[active_slot].
- user_irq[j] = OR over k of (slot_irq_i[3k+j] & irq_en[k]), combinational.
- Reset values:
  - FSM IDLE.
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - slot_cyc_o = 0, slot_stb_o = 0.
  - active_slot = 0, irq_en = 0, soft_rst = 0.
  - Timeout flag = 0, last timed-out slot = 0.
  - slot_rst_o = all 1 for the first cycle after reset, then 0.
- Reset during FWD: drop slot cyc/stb next cycle, no ack issued.

Optional Feature:
- Macro: USER_PROJECT_MUX_TIMEOUT_EN.
- Defined: timeout counter, ERR_DATA path and STATUS[0] / STATUS[10:8] are present as described above.
- Undefined: FWD waits indefinitely for the slot ack; STATUS reads 0; no counter logic is synthesised.

Test Plan:
- Reset check: assert wb_rst_i for 3 cycles -> io_oeb equals slot 0 oeb; CTRL reads 0x0; user_irq = 0; slot_rst_o all 1, then 0.
- CTRL write: write 0x30F0_0000 = 0x0003_0302 with sel = 4'b0111 -> CTRL readback 0x0003_0302; io_out follows slot 2; slots 0 and 1 held in reset.
- Slot read with delay: read 0x3010_0008 while slot 1 acks after 3 cycles with 0x1234_5678 -> only slot_stb_o[1] asserted; slot_adr_o = 0x3010_0008; mgmt ack 1 cycle after slot ack with 0x1234_5678.
- Timeout (macro defined): read slot 3, which never acks -> ack after TIMEOUT_CYCLES with 0xDEAD_BEEF; STATUS = 0x301. Write 1 to STATUS[0] -> STATUS = 0x300.
- Unmapped access: read 0x3050_0000 with NUM_SLOTS = 4 -> ack on 2nd cycle, data 0; no slot_cyc_o asserted.
- IRQ masking: slot 2 raises irq[1] with irq_en = 0 -> user_irq = 0; set irq_en[2] -> user_irq = 3'b010.
